// File: rtl/imem_loader.sv
// imem_loader
//
// Boot-time program loader for the instruction memory. It takes a
// length-prefixed byte stream and writes the words to memory, then releases the CPU.
//
// Stream format:
//   - 16-bit word count N, low byte first.
//   - N words, each sent as 4 bytes, least significant byte first.
//   - Optionally, one checksum byte.
// Words are written to word addresses 0..N-1. The CPU is held in reset until a
// load completes successfully.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When this macro is defined, one extra byte follows the data. That byte must
//   equal the XOR of all data bytes (0x00 when N = 0). A mismatch ends the load
//   in the error state, and the CPU stays held.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   i_start       single-cycle load request (honoured in IDLE/DONE/ERROR)
//   i_byte_valid  byte source has a byte
//   i_byte        stream byte
//   o_byte_ready  loader accepts a byte this cycle
//   o_imem_we     instruction-memory write strobe (one cycle per word)
//   o_imem_addr   instruction-memory word address
//   o_imem_wdata  instruction-memory write data
//   o_cpu_hold    CPU reset; high while no successful load has finished
//   o_done        last load succeeded
//   o_error       last load failed
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_byte_ready,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [31:0]           o_imem_wdata,
  output logic                  o_cpu_hold,
  output logic                  o_done,
  output logic                  o_error
);

  // DRAIN adds the cycle between the final write strobe and the CPU release.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    S_CHK    = 3'd7
`endif
  } state_t;

  localparam logic [16:0]         DEPTH   = 17'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q;
  logic [7:0]            len_lo_q;
  logic [ADDR_WIDTH:0]   len_q;
  // One bit wider than the address, so that N = 2^ADDR_WIDTH does not wrap.
  logic [ADDR_WIDTH:0]   idx_q;
  logic [1:0]            bcnt_q;
  // First three bytes of the current word; the newest byte enters at the top.
  logic [23:0]           shift_q;
  logic                  ready_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  hold_q;
  logic                  done_q;
  logic                  error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            chk_q;
  logic [7:0]            chk_d;
`endif

  logic                  accept;
  logic [16:0]           len_ext;
  logic [ADDR_WIDTH:0]   idx_d;
  logic [31:0]           word_d;
  logic                  last_word;

  assign accept    = i_byte_valid && ready_q;
  assign len_ext   = {1'b0, i_byte, len_lo_q};
  assign idx_d     = idx_q + IDX_ONE;
  assign word_d    = {i_byte, shift_q};
  assign last_word = (idx_d == len_q);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign chk_d     = chk_q ^ i_byte;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      len_lo_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (state_q == S_DONE) begin
            done_q <= 1'b1;
            hold_q <= 1'b0;
          end
          if (state_q == S_ERROR) begin
            error_q <= 1'b1;
            hold_q  <= 1'b1;
          end
          // A restart overrides the status updates above.
          if (i_start) begin
            state_q <= S_LEN_LO;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            hold_q  <= 1'b1;
            idx_q   <= '0;
            bcnt_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            len_lo_q <= i_byte;
            state_q  <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            len_q <= len_ext[ADDR_WIDTH:0];
            if (len_ext > DEPTH) begin
              state_q <= S_ERROR;
              ready_q <= 1'b0;
            end else if (len_ext == 17'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_q <= S_CHK;
`else
              state_q <= S_DRAIN;
              ready_q <= 1'b0;
`endif
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q  <= chk_d;
`endif
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              wdata_q <= word_d;
              addr_q  <= idx_q[ADDR_WIDTH-1:0];
              we_q    <= 1'b1;
              idx_q   <= idx_d;
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_q <= S_CHK;
`else
                state_q <= S_DRAIN;
                ready_q <= 1'b0;
`endif
              end
            end else begin
              shift_q <= {i_byte, shift_q[23:8]};
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            ready_q <= 1'b0;
            state_q <= (i_byte == chk_q) ? S_DRAIN : S_ERROR;
          end
        end
`endif

        S_DRAIN: begin
          state_q <= S_DONE;
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte_ready = ready_q;
  assign o_imem_we    = we_q;
  assign o_imem_addr  = addr_q;
  assign o_imem_wdata = wdata_q;
  assign o_cpu_hold   = hold_q;
  assign o_done       = done_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef logic [7:0] u8_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic          i_byte_valid;
  logic [7:0]    i_byte;
  logic          o_byte_ready;
  logic          o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_wdata;
  logic          o_cpu_hold;
  logic          o_done;
  logic          o_error;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_cpu_hold   (o_cpu_hold),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  always #5 clk = ~clk;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!reset && o_imem_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h, expected no write",
                 o_imem_addr, o_imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(o_imem_addr), 32'(e.addr));
        check("wr_data", o_imem_wdata, e.data);
      end
    end
  end

  // Reference model. It works from the stream contents and pushes the writes
  // the stream should produce. It returns whether the load should fail.
  task automatic model(input u8_t s[$], output bit exp_err);
    int  n;
    wr_t e;
`ifdef IMEM_LOADER_CHECKSUM_EN
    u8_t x;
    x = 8'h00;
`endif
    n = int'({s[1], s[0]});
    exp_err = 1'b0;
    if (n > DEPTH) begin
      exp_err = 1'b1;
    end else begin
      for (int w = 0; w < n; w++) begin
        e.addr = AW'(w);
        e.data = {s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]};
        exp_q.push_back(e);
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int k = 0; k < 4; k++) x = x ^ s[2+4*w+k];
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (s[2+4*n] != x) exp_err = 1'b1;
`endif
    end
  endtask

  // Builds a stream of n random words. When bad_chk is set and the checksum
  // is enabled, the checksum byte is deliberately corrupted.
  task automatic build(input int n, input bit bad_chk, output u8_t s[$]);
    u8_t b;
    u8_t x;
    s.delete();
    x = 8'h00;
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    if (n <= DEPTH) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        s.push_back(b);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (bad_chk) x = x ^ 8'($urandom_range(1, 255));
      s.push_back(x);
`else
      if (bad_chk) x = 8'h00;
`endif
    end
  endtask

  // Stream driver. mode 0 = full rate. mode 1 = valid every other cycle.
  // mode 2 = random valid, with stray start pulses during the load.
  task automatic send(input u8_t s[$], input int mode, output bit to);
    int idx;
    int guard;
    bit acc;
    idx = 0;
    guard = 0;
    to = 1'b0;
    while (idx < s.size()) begin
      @(negedge clk);
      i_start = 1'b0;
      if (mode == 0)      i_byte_valid = 1'b1;
      else if (mode == 1) i_byte_valid = guard[0];
      else                i_byte_valid = ($urandom_range(0, 2) != 0);
      if (mode == 2 && idx > 0 && $urandom_range(0, 7) == 0) i_start = 1'b1;
      i_byte = i_byte_valid ? s[idx] : 8'($urandom);
      acc = i_byte_valid && o_byte_ready;
      @(posedge clk);
      if (acc) idx++;
      guard++;
      if (guard > 4 * s.size() + 64) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    i_start = 1'b1;
    i_byte_valid = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    check({tag, "_start_done"},  32'(o_done),       32'd0);
    check({tag, "_start_error"}, 32'(o_error),      32'd0);
    check({tag, "_start_hold"},  32'(o_cpu_hold),   32'd1);
    check({tag, "_start_ready"}, 32'(o_byte_ready), 32'd1);
  endtask

  // Called right after the edge that accepted the last byte.
  task automatic finish_load(input bit exp_err, input string tag);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      i_byte_valid = 1'b0;
      i_start = 1'b0;
      if (k == 0) check({tag, "_hold_pre"}, 32'(o_cpu_hold), 32'd1);
      if (o_done || o_error) break;
    end
    check({tag, "_latency"},   32'(k),            exp_err ? 32'd1 : 32'd2);
    check({tag, "_done"},      32'(o_done),       32'(!exp_err));
    check({tag, "_error"},     32'(o_error),      32'(exp_err));
    check({tag, "_hold"},      32'(o_cpu_hold),   32'(exp_err));
    check({tag, "_ready_end"}, 32'(o_byte_ready), 32'd0);
    check({tag, "_sb_empty"},  32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_load(input u8_t s[$], input int mode, input string tag,
                          input bit use_model, input bit exp_err_in);
    bit exp_err;
    bit to;
    if (use_model) model(s, exp_err);
    else           exp_err = exp_err_in;
    do_start(tag);
    send(s, mode, to);
    check({tag, "_all_bytes_taken"}, 32'(to), 32'd0);
    finish_load(exp_err, tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    i_start = 1'b0;
    i_byte_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u8_t s[$];
    u8_t part[$];
    wr_t e;
    bit  to;
    int  n;

    reset = 1'b1;
    i_start = 1'b0;
    i_byte_valid = 1'b0;
    i_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_hold",  32'(o_cpu_hold),   32'd1);
    check("rst_done",  32'(o_done),       32'd0);
    check("rst_error", 32'(o_error),      32'd0);
    check("rst_we",    32'(o_imem_we),    32'd0);
    check("rst_ready", 32'(o_byte_ready), 32'd0);
    check("rst_addr",  32'(o_imem_addr),  32'd0);
    check("rst_wdata", o_imem_wdata,      32'd0);
    reset = 1'b0;

    // Bytes offered without a start must be ignored.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      i_byte_valid = 1'b1;
      i_byte = 8'($urandom);
    end
    @(negedge clk);
    i_byte_valid = 1'b0;
    check("nostart_ready", 32'(o_byte_ready), 32'd0);
    check("nostart_hold",  32'(o_cpu_hold),   32'd1);
    check("nostart_done",  32'(o_done),       32'd0);

    // Directed two-word program, with the write values written out by hand.
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(8'hB0);
`endif
    for (int m = 0; m < 2; m++) begin
      e.addr = 8'd0; e.data = 32'h00100013; exp_q.push_back(e);
      e.addr = 8'd1; e.data = 32'h00200093; exp_q.push_back(e);
      run_load(s, m, (m == 0) ? "dir_full" : "dir_toggle", 1'b0, 1'b0);
    end

    // A length larger than the memory must fail without writing anything.
    s = '{8'h01, 8'h01};
    run_load(s, 0, "len257", 1'b0, 1'b1);

    // Reset in the middle of a word, followed by a clean reload.
    build(1, 1'b0, s);
    part.delete();
    for (int i = 0; i < 4; i++) part.push_back(s[i]);
    do_start("abort");
    send(part, 0, to);
    check("abort_bytes_taken", 32'(to), 32'd0);
    apply_reset();
    check("abort_hold",  32'(o_cpu_hold),   32'd1);
    check("abort_done",  32'(o_done),       32'd0);
    check("abort_error", 32'(o_error),      32'd0);
    check("abort_ready", 32'(o_byte_ready), 32'd0);
    build(1, 1'b0, s);
    run_load(s, 0, "reload", 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    s = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h03};
    e.addr = 8'd0; e.data = 32'h00100013; exp_q.push_back(e);
    run_load(s, 0, "chk_good", 1'b0, 1'b0);
    s = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h04};
    e.addr = 8'd0; e.data = 32'h00100013; exp_q.push_back(e);
    run_load(s, 0, "chk_bad", 1'b0, 1'b1);
`endif

    // Empty program.
    build(0, 1'b0, s);
    run_load(s, 0, "empty", 1'b1, 1'b0);

    // Randomized loads, including oversized lengths and (when the checksum is
    // enabled) corrupted checksums.
    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(0, 5) == 0) n = DEPTH + 1 + int'($urandom_range(0, 65535 - DEPTH - 1));
      else                           n = int'($urandom_range(0, 6));
      build(n, ($urandom_range(0, 3) == 0), s);
      run_load(s, int'($urandom_range(0, 2)), $sformatf("rand%0d", it), 1'b1, 1'b0);
    end

    // Full memory, with no wrap of the word index.
    build(DEPTH, 1'b0, s);
    run_load(s, 0, "full_mem", 1'b1, 1'b0);

    // Exactly one word over the limit.
    build(DEPTH + 1, 1'b0, s);
    run_load(s, 1, "over_by_one", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader feeding the instruction memory that the fetch stage reads. It receives a length-prefixed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them to sequential instruction-memory word addresses starting at 0. It holds the CPU in reset until a load completes successfully. It sits between the host/bench byte source and the instruction-memory write port, beside `cpu_top`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: instruction-memory word-address width; depth = 2^ADDR_WIDTH words.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  single-cycle request to begin a load.
- `i_byte_valid`  in  1  byte source has a byte.
- `i_byte`  in  8  stream byte.
- `o_byte_ready`  out  1  loader accepts a byte this cycle.
- `o_imem_we`  out  1  instruction-memory write strobe.
- `o_imem_addr`  out  ADDR_WIDTH  word address.
- `o_imem_wdata`  out  32  word data.
- `o_cpu_hold`  out  1  drives the CPU `reset`; high = CPU held.
- `o_done`  out  1  last load succeeded.
- `o_error`  out  1  last load failed.

## Operation
- Reset values: state IDLE; `o_byte_ready`=0, `o_imem_we`=0, `o_imem_addr`=0, `o_imem_wdata`=0, `o_cpu_hold`=1, `o_done`=0, `o_error`=0. Reset mid-load aborts immediately; no partial state survives.
- Byte accepted only on `i_byte_valid && o_byte_ready`. `o_byte_ready` is 1 in LEN_LO, LEN_HI, DATA (and CHK); 0 otherwise.
- States: IDLE -> (i_start) -> LEN_LO -> LEN_HI -> DATA -> [CHK] -> DONE; any -> ERROR on fault.
- LEN_LO/LEN_HI: 16-bit word count N, low byte first.
- After LEN_HI: N > 2^ADDR_WIDTH -> ERROR. N = 0 -> DONE (or CHK if enabled). Else DATA.
- DATA: bytes little-endian (first byte = bits 7:0). On the 4th byte of a word, word is latched to `o_imem_wdata`, `o_imem_addr` = word index (0..N-1), `o_imem_we` pulses exactly one cycle. Next byte may be accepted in the same cycle as the strobe; it does not disturb `o_imem_wdata`.
- After word N-1 written -> DONE (or CHK).
- DONE: `o_cpu_hold`=0, `o_done`=1. ERROR: `o_cpu_hold`=1, `o_error`=1.
- `i_start` honoured only in IDLE, DONE, ERROR; ignored during LEN/DATA/CHK. Restart clears `o_done`/`o_error` and reasserts `o_cpu_hold` on the next cycle.
- Word index counter is ADDR_WIDTH+1 bits so N = 2^ADDR_WIDTH loads the full memory without wrap.

## Timing
- Byte accepted at edge T: state/counters update at T.
- 4th byte of a word accepted at edge T: `o_imem_we`=1 in cycle T..T+1, addr/data stable with it.
- Final word strobe in cycle T..T+1; `o_cpu_hold` falls and `o_done` rises at edge T+2 (one cycle after the strobe ends, so the CPU never fetches before the last write lands).
- Length fault: `o_error` rises on the edge after LEN_HI byte is accepted.
- Maximum throughput: one byte per cycle, no bubbles.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: after the data (or after LEN_HI when N = 0) one extra CHK byte is accepted; it must equal the XOR of all data bytes (0x00 for N = 0). Match -> DONE; mismatch -> ERROR (memory already written, CPU stays held).
- Undefined: no CHK state, no checksum logic; stream ends after the last data byte.

## Test plan
- Reset -> `o_cpu_hold`=1, `o_done`=0, `o_error`=0, `o_imem_we`=0; no writes until `i_start`.
- start; bytes 02 00 13 00 10 00 93 00 20 00 (N=2) at full rate -> writes addr0=0x00100013, addr1=0x00200093; `o_done`=1, `o_cpu_hold`=0 two cycles after last byte.
- Same stream with `i_byte_valid` toggling every other cycle -> identical writes, no duplicate strobes.
- ADDR_WIDTH=8, length bytes 01 01 (N=257) -> `o_error`=1, no `o_imem_we`, hold stays 1.
- Assert `reset` after 2 of 4 data bytes, then reload N=1 -> only the reloaded word written at addr 0.
- With `IMEM_LOADER_CHECKSUM_EN`: N=1, data 13 00 10 00, CHK 0x03 -> DONE; CHK 0x04 -> ERROR, `o_cpu_hold`=1.
